// File: rtl/mem_pkg.sv
// Shared packet-buffer definitions used by the egress reader (and the writer).
// A block is {payload, footer}. Byte 0 of a block is the most significant
// payload byte. The footer carries the index of the next block in the frame
// and the end-of-packet flag.
// No ports (package).
package mem_pkg;

  localparam int ADDR_W        = 8;
  localparam int PAYLOAD_BYTES = 62;
  localparam int PAYLOAD_BITS  = PAYLOAD_BYTES * 8;

  typedef struct packed {
    logic              eop;
    logic [ADDR_W-1:0] nxt_idx;
  } footer_t;

  localparam int FOOTER_BITS = $bits(footer_t);
  localparam int BLOCK_BITS  = PAYLOAD_BITS + FOOTER_BITS;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT,
    RD_STREAM,
    RD_FREE_LAST
  } rd_state_t;

endpackage

// File: rtl/block_serializer.sv
// Holds one block payload and emits it as PAYLOAD_BYTES single-byte beats,
// most significant byte first, under a valid/ready handshake.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load_i            capture payload_i and start emitting from byte 0
//   payload_i         block payload
//   flush_i           drop whatever is held (frame abort)
//   ready_i           downstream accepts the current byte
//   valid_o           a byte is being presented
//   data_o            current byte
//   first_o           current byte is byte 0 of the block
//   last_o            current byte is the final byte of the block
module block_serializer
  import mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [PAYLOAD_BITS-1:0] payload_i,
  input  logic                    flush_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [7:0]              data_o,
  output logic                    first_o,
  output logic                    last_o
);

  localparam int CNT_W = $clog2(PAYLOAD_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_BYTES - 1);

  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    full_q, full_d;

  // Load has priority over shifting; the owner never loads a buffer that is
  // still emitting, so the two never collide in practice.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      shift_d = payload_i;
      cnt_d   = '0;
      full_d  = 1'b1;
    end else if (full_q && ready_i) begin
      shift_d = shift_q << 8;
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_CNT) begin
        full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = shift_q[PAYLOAD_BITS-1 -: 8];
  assign first_o = (cnt_q == '0);
  assign last_o  = (cnt_q == LAST_CNT);

endmodule

// File: rtl/memory_read_ctrl.sv
// Egress reader for the shared packet buffer. Walks a frame's linked list of
// blocks from a head index, streams the payload as byte beats with
// begin/end markers, and returns every consumed block to the free list.
// Optional feature: define MEM_RD_PREFETCH_EN for a second block buffer so the
// next block is fetched while the current one streams.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_valid_i/addr_i/ready_o  head index handshake from the port arbiter
//   mem_ready_i, mem_re_o, mem_addr_o   block read request
//   mem_rvalid_i, mem_rdata_i   block read response
//   fl_free_req_o, fl_free_block_idx_o, fl_free_gnt_i   free-list return
//   data_o, data_valid_o, data_begin_o, data_end_o, data_ready_i  byte stream
//   abort_o                    one-cycle pulse when the chain limit is hit
module memory_read_ctrl
  import mem_pkg::*;
#(
  parameter int MAX_FRAME_BLOCKS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid_i,
  input  logic [ADDR_W-1:0]     start_addr_i,
  output logic                  start_ready_o,
  input  logic                  mem_ready_i,
  output logic                  mem_re_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic                  mem_rvalid_i,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i,
  output logic                  fl_free_req_o,
  output logic [ADDR_W-1:0]     fl_free_block_idx_o,
  input  logic                  fl_free_gnt_i,
  output logic [7:0]            data_o,
  output logic                  data_valid_o,
  output logic                  data_begin_o,
  output logic                  data_end_o,
  input  logic                  data_ready_i,
  output logic                  abort_o
);

  localparam int BLK_W = $clog2(MAX_FRAME_BLOCKS + 1);
  localparam logic [BLK_W-1:0] BLK_LIMIT = BLK_W'(MAX_FRAME_BLOCKS);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cur_idx_q, cur_idx_d;
  logic [ADDR_W-1:0] nxt_idx_q, nxt_idx_d;
  logic [ADDR_W-1:0] free_idx_q, free_idx_d;
  logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic              eop_q, eop_d;
  logic              first_q, first_d;
  logic              free_req_q, free_req_d;
  logic              abort, capture, start_rdy, rd_go, xfer;
  logic              out_valid, out_first, out_last, out_eop;
  logic [7:0]        out_data;
  footer_t           rd_footer;
  logic [PAYLOAD_BITS-1:0] rd_payload;

  assign rd_footer  = footer_t'(mem_rdata_i[FOOTER_BITS-1:0]);
  assign rd_payload = mem_rdata_i[BLOCK_BITS-1 -: PAYLOAD_BITS];

`ifdef MEM_RD_PREFETCH_EN
  // Two ping-pong buffers: wr_sel points at the buffer the next read fills,
  // rd_sel at the one currently streaming. Each buffer keeps its own eop.
  logic       rd_sel_q, rd_sel_d, wr_sel_q, wr_sel_d;
  logic [1:0] eop_buf_q, eop_buf_d;
  logic [1:0] ser_load, ser_ready, ser_valid, ser_first, ser_last;
  logic [7:0] ser_data [2];
  logic       stream_idle;

  for (genvar g = 0; g < 2; g++) begin : g_ser
    assign ser_load[g]  = capture && (wr_sel_q == 1'(g));
    assign ser_ready[g] = data_ready_i && (rd_sel_q == 1'(g));
    block_serializer u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (ser_load[g]),
      .payload_i (rd_payload),
      .flush_i   (abort),
      .ready_i   (ser_ready[g]),
      .valid_o   (ser_valid[g]),
      .data_o    (ser_data[g]),
      .first_o   (ser_first[g]),
      .last_o    (ser_last[g])
    );
  end

  assign out_valid   = ser_valid[rd_sel_q];
  assign out_data    = ser_data[rd_sel_q];
  assign out_first   = ser_first[rd_sel_q];
  assign out_last    = ser_last[rd_sel_q];
  assign out_eop     = eop_buf_q[rd_sel_q];
  assign stream_idle = (ser_valid == 2'b00);
  assign rd_go       = mem_ready_i && !free_req_q && !ser_valid[wr_sel_q];

  // Buffer pointers advance on load and on the final byte of a block; an
  // abort empties both buffers so the pointers restart together.
  always_comb begin
    rd_sel_d  = rd_sel_q;
    wr_sel_d  = wr_sel_q;
    eop_buf_d = eop_buf_q;
    if (abort) begin
      rd_sel_d = 1'b0;
      wr_sel_d = 1'b0;
    end else begin
      if (capture) begin
        eop_buf_d[wr_sel_q] = rd_footer.eop;
        wr_sel_d            = !wr_sel_q;
      end
      if (xfer && out_last) begin
        rd_sel_d = !rd_sel_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel_q  <= 1'b0;
      wr_sel_q  <= 1'b0;
      eop_buf_q <= '0;
    end else begin
      rd_sel_q  <= rd_sel_d;
      wr_sel_q  <= wr_sel_d;
      eop_buf_q <= eop_buf_d;
    end
  end
`else
  block_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (capture),
    .payload_i (rd_payload),
    .flush_i   (abort),
    .ready_i   (data_ready_i),
    .valid_o   (out_valid),
    .data_o    (out_data),
    .first_o   (out_first),
    .last_o    (out_last)
  );

  assign out_eop = eop_q;
  assign rd_go   = mem_ready_i && !free_req_q;
`endif

  assign xfer = out_valid && data_ready_i;

  // Next-state and handshake logic. The free handshake and the begin marker
  // are updated ahead of the state case so any state may observe a grant or
  // a transfer.
  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    nxt_idx_d  = nxt_idx_q;
    free_idx_d = free_idx_q;
    blk_cnt_d  = blk_cnt_q;
    eop_d      = eop_q;
    first_d    = first_q;
    free_req_d = free_req_q;
    start_rdy  = 1'b0;
    mem_re_o   = 1'b0;
    mem_addr_o = '0;
    abort      = 1'b0;
    capture    = 1'b0;

    if (free_req_q && fl_free_gnt_i) begin
      free_req_d = 1'b0;
    end
    if (xfer) begin
      first_d = 1'b0;
    end

    case (state_q)
      RD_IDLE: begin
        start_rdy = 1'b1;
        if (start_valid_i) begin
          cur_idx_d = start_addr_i;
          blk_cnt_d = '0;
          first_d   = 1'b1;
          eop_d     = 1'b0;
          state_d   = RD_REQ;
        end
      end
      RD_REQ: begin
        if (rd_go) begin
          mem_re_o   = 1'b1;
          mem_addr_o = cur_idx_q;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid_i) begin
          // The payload is captured (or discarded) now, so the block can be
          // handed back to the free list immediately.
          free_req_d = 1'b1;
          free_idx_d = cur_idx_q;
          if (blk_cnt_q == BLK_LIMIT) begin
            abort   = 1'b1;
            state_d = RD_FREE_LAST;
          end else begin
            capture   = 1'b1;
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
            nxt_idx_d = rd_footer.nxt_idx;
            eop_d     = rd_footer.eop;
            state_d   = RD_STREAM;
          end
        end
      end
      RD_STREAM: begin
`ifdef MEM_RD_PREFETCH_EN
        if (eop_q) begin
          if (stream_idle) begin
            state_d = RD_FREE_LAST;
          end
        end else begin
          cur_idx_d = nxt_idx_q;
          state_d   = RD_REQ;
        end
`else
        if (xfer && out_last) begin
          if (eop_q) begin
            state_d = RD_FREE_LAST;
          end else begin
            cur_idx_d = nxt_idx_q;
            state_d   = RD_REQ;
          end
        end
`endif
      end
      RD_FREE_LAST: begin
        if (!free_req_q || fl_free_gnt_i) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      cur_idx_q  <= '0;
      nxt_idx_q  <= '0;
      free_idx_q <= '0;
      blk_cnt_q  <= '0;
      eop_q      <= 1'b0;
      first_q    <= 1'b0;
      free_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      nxt_idx_q  <= nxt_idx_d;
      free_idx_q <= free_idx_d;
      blk_cnt_q  <= blk_cnt_d;
      eop_q      <= eop_d;
      first_q    <= first_d;
      free_req_q <= free_req_d;
    end
  end

  // start_ready is gated by reset so every output reads 0 while reset is held.
  assign start_ready_o       = start_rdy && rst_n;
  assign fl_free_req_o       = free_req_q;
  assign fl_free_block_idx_o = free_idx_q;
  assign data_valid_o        = out_valid;
  assign data_o              = out_valid ? out_data : 8'h00;
  assign data_begin_o        = out_valid && first_q && out_first;
  assign data_end_o          = out_valid && out_eop && out_last;
  assign abort_o             = abort;

endmodule
